pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//   Program counter and instruction-fetch stage of the Nano MIPS core. Holds PC, computes the
//   next PC from the controller's LdPC/SelJMP/SelDesv strobes, fetches from instruction memory
//   over a rd/ack handshake and registers the word into IR. Its OP field drives the controller.
// PARAMETERS
//   AW  8   PC / instruction-memory address width (bits)
//   IW  16  instruction width; OP = IR[IW-1:IW-4], imm/target = IR[7:0]
// PORTS
//   clk        in   1   system clock; all state updates on rising edge
//   rst        in   1   reset, asynchronous, active-high
//   LdPC       in   1   one-cycle strobe from controller: advance PC
//   SelJMP     in   1   with LdPC: load absolute jump target
//   SelDesv    in   1   with LdPC: take relative branch
//   imem_addr  out  AW  instruction-memory address (= pc while fetching)
//   imem_rd    out  1   read request, level, held until ack
//   imem_ack   in   1   memory data valid on imem_data this cycle
//   imem_data  in   IW  instruction word from memory
//   pc         out  AW  current program counter
//   instr      out  IW  instruction register (IR)
//   OP         out  4   IR[IW-1:IW-4], to controller
//   instr_vld  out  1   IR holds the word fetched from the current pc
//   busy       out  1   fetch in progress (state FETCH); for future stall logic
// BEHAVIOUR
//   Reset (rst=1, async): pc=0, instr=0 (NOP), instr_vld=0, state=BOOT, imem_rd=0, busy=0.
//   FSM states BOOT, FETCH, IDLE:
//   - BOOT: first clock after rst release -> FETCH. No request issued in BOOT.
//   - FETCH: imem_rd=1, imem_addr=pc, busy=1. On imem_ack=1 (and no LdPC): instr<=imem_data,
//     instr_vld<=1, -> IDLE. Without ack: remain, address and rd stable.
//   - IDLE: imem_rd=0, busy=0, IR and pc held. LdPC=1 -> update pc, instr_vld<=0, -> FETCH.
//   Next-PC (evaluated only on LdPC=1; priority SelJMP > SelDesv > increment):
//   - SelJMP=1 : pc <= IR[AW-1:0] zero-extended (absolute target).
//   - SelDesv=1: pc <= pc + 1 + sext(IR[7:0]) (relative to the following instruction).
//   - else     : pc <= pc + 1.
//   - All arithmetic modulo 2^AW; wrap silent (pc=2^AW-1 +1 -> 0). No overflow flag.
//   LdPC in FETCH (simultaneous events): redirect wins. pc updated per above, any ack in the
//   same cycle is discarded (IR unchanged), instr_vld<=0, stay in FETCH with new address
//   (imem_rd stays 1, new address from next cycle).
//   LdPC in BOOT: ignored.
//   SelJMP/SelDesv without LdPC: ignored, no state change.
//   Latency: LdPC at edge n -> new pc and imem_rd from n+1; with zero-wait memory (ack in the
//   cycle after LdPC) instr/OP valid after edge n+2, in time for the controller's decode state.
//   rst asserted mid-fetch: immediate return to reset values; pending request dropped; memory
//   must tolerate imem_rd falling without ack.
//   OP/instr are registered outputs; imem_rd, imem_addr, busy are decoded from state/pc only
//   (no combinational path from any input).
// TESTING
//   1 Reset release, imem_ack tied 1, mem[0]=16'h8105 -> imem_rd=1 addr 0 on 2nd clock;
//     instr=16'h8105, OP=4'h8, instr_vld=1 after 3rd clock.
//   2 pc=8'h10, IDLE, LdPC=1 only -> pc=8'h11, fetch addr 8'h11; ack 3 cycles late ->
//     imem_rd/addr held stable those 3 cycles, IR loads on ack.
//   3 IR=16'hD03C, LdPC+SelJMP+SelDesv -> pc=8'h3C (jump priority); IR=16'hB0FE at pc=8'h20,
//     LdPC+SelDesv -> pc=8'h1F (1 + -2).
//   4 pc=8'hFF, LdPC -> pc=8'h00; IR=16'hB07F at pc=8'hF0, SelDesv -> pc=8'h70 (wrap).
//   5 LdPC in same cycle as imem_ack during FETCH -> IR unchanged, instr_vld=0, new pc fetched.
//   6 rst pulsed mid-FETCH (ack held 0) -> outputs at reset values without a clock edge;
//     after release, BOOT then fetch from addr 0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction-memory rd/ack fetch bus between pc_fetch and instruction memory
interface pc_fetch_if #(
  parameter int AW = 8,
  parameter int IW = 16
);
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic          imem_ack;
  logic [IW-1:0] imem_data;

  modport master (output imem_addr, output imem_rd, input imem_ack, input imem_data);
  modport slave  (input imem_addr, input imem_rd, output imem_ack, output imem_data);
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction-fetch stage of the Nano MIPS core
module pc_fetch #(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LdPC,
  input  logic          SelJMP,
  input  logic          SelDesv,
  pc_fetch_if.master    imem,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] instr,
  output logic [3:0]    OP,
  output logic          instr_vld,
  output logic          busy
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] IDLE  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] rel_off;
  logic [AW-1:0] next_pc;

  // Branch offset is relative to the instruction after the branch.
  always_comb begin
    pc_inc  = pc + AW'(1);
    rel_off = AW'($signed(instr[7:0]));
    next_pc = pc_inc;
    if (SelJMP)
      next_pc = instr[AW-1:0];
    else if (SelDesv)
      next_pc = pc_inc + rel_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= '0;
      instr     <= '0;
      instr_vld <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          // A redirect wins over a same-cycle ack; the stale word is dropped.
          if (LdPC) begin
            pc        <= next_pc;
            instr_vld <= 1'b0;
          end else if (imem.imem_ack) begin
            instr     <= imem.imem_data;
            instr_vld <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: begin
          if (LdPC) begin
            pc        <= next_pc;
            instr_vld <= 1'b0;
            state     <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign imem.imem_rd   = (state == FETCH);
  assign imem.imem_addr = pc;
  assign busy           = (state == FETCH);
  assign OP             = instr[IW-1:IW-4];

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LdPC = 1'b0;
  logic        SelJMP = 1'b0;
  logic        SelDesv = 1'b0;
  logic        ack = 1'b0;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [3:0]  OP;
  logic        instr_vld;
  logic        busy;
  logic [15:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_if #(.AW(8), .IW(16)) bus ();

  assign bus.imem_ack  = ack;
  assign bus.imem_data = mem[bus.imem_addr];

  pc_fetch #(.AW(8), .IW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .LdPC      (LdPC),
    .SelJMP    (SelJMP),
    .SelDesv   (SelDesv),
    .imem      (bus.master),
    .pc        (pc),
    .instr     (instr),
    .OP        (OP),
    .instr_vld (instr_vld),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One controller strobe cycle, then strobes drop.
  task automatic strobe(input logic j, input logic d);
    LdPC = 1'b1; SelJMP = j; SelDesv = d;
    tick();
    LdPC = 1'b0; SelJMP = 1'b0; SelDesv = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h8105;
    mem[8'h05] = 16'h0010;
    mem[8'h10] = 16'hD03C;
    mem[8'h3C] = 16'h1010;
    mem[8'h11] = 16'h2020;
    mem[8'h20] = 16'hB0FE;
    mem[8'h1F] = 16'h30FF;
    mem[8'hFF] = 16'h40F0;
    mem[8'hF0] = 16'hB07F;
    mem[8'h70] = 16'h5555;

    // Reset state
    tick();
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instr, 16'h0000);
    check("rst_vld", instr_vld, 1'b0);
    check("rst_rd", bus.imem_rd, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Boot and first fetch with ack tied high
    ack = 1'b1;
    rst = 1'b0;
    tick();
    check("boot_rd", bus.imem_rd, 1'b1);
    check("boot_addr", bus.imem_addr, 8'h00);
    check("boot_busy", busy, 1'b1);
    tick();
    check("f0_instr", instr, 16'h8105);
    check("f0_op", OP, 4'h8);
    check("f0_vld", instr_vld, 1'b1);
    check("f0_rd", bus.imem_rd, 1'b0);

    // Select strobes without LdPC are ignored
    SelJMP = 1'b1; SelDesv = 1'b1;
    tick();
    SelJMP = 1'b0; SelDesv = 1'b0;
    check("nold_pc", pc, 8'h00);
    check("nold_rd", bus.imem_rd, 1'b0);

    // Walk to pc=0x10 with IR=D03C
    strobe(1'b1, 1'b0);
    check("j05_pc", pc, 8'h05);
    check("j05_vld", instr_vld, 1'b0);
    tick();
    check("j05_instr", instr, 16'h0010);
    strobe(1'b1, 1'b0);
    tick();
    check("j10_pc", pc, 8'h10);
    check("j10_instr", instr, 16'hD03C);

    // Jump has priority over relative branch
    strobe(1'b1, 1'b1);
    check("prio_pc", pc, 8'h3C);
    tick();
    check("prio_instr", instr, 16'h1010);
    strobe(1'b1, 1'b0);
    tick();
    check("back10_pc", pc, 8'h10);

    // Plain increment, ack three cycles late
    ack = 1'b0;
    strobe(1'b0, 1'b0);
    check("inc_pc", pc, 8'h11);
    for (int i = 0; i < 3; i++) begin
      check("wait_rd", bus.imem_rd, 1'b1);
      check("wait_addr", bus.imem_addr, 8'h11);
      check("wait_vld", instr_vld, 1'b0);
      tick();
    end
    check("wait_instr_held", instr, 16'hD03C);
    ack = 1'b1;
    tick();
    check("late_instr", instr, 16'h2020);
    check("late_vld", instr_vld, 1'b1);
    check("late_busy", busy, 1'b0);

    // Backward relative branch: 0x20 + 1 - 2
    strobe(1'b1, 1'b0);
    tick();
    check("b20_instr", instr, 16'hB0FE);
    strobe(1'b0, 1'b1);
    check("rel_back_pc", pc, 8'h1F);
    tick();
    check("b1f_instr", instr, 16'h30FF);

    // Increment wrap 0xFF -> 0x00
    strobe(1'b1, 1'b0);
    tick();
    check("bff_instr", instr, 16'h40F0);
    ack = 1'b1;
    strobe(1'b0, 1'b0);
    check("wrap_pc", pc, 8'h00);

    // Redirect during FETCH with simultaneous ack: ack dropped
    strobe(1'b1, 1'b0);
    check("redir_pc", pc, 8'hF0);
    check("redir_instr", instr, 16'h40F0);
    check("redir_vld", instr_vld, 1'b0);
    check("redir_rd", bus.imem_rd, 1'b1);
    check("redir_addr", bus.imem_addr, 8'hF0);
    tick();
    check("bf0_instr", instr, 16'hB07F);

    // Relative branch wrap: 0xF0 + 1 + 0x7F
    ack = 1'b0;
    strobe(1'b0, 1'b1);
    check("rel_wrap_pc", pc, 8'h70);
    tick();
    check("midf_rd", bus.imem_rd, 1'b1);

    // Asynchronous reset mid-fetch
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 8'h00);
    check("arst_instr", instr, 16'h0000);
    check("arst_vld", instr_vld, 1'b0);
    check("arst_rd", bus.imem_rd, 1'b0);
    check("arst_busy", busy, 1'b0);
    tick();
    ack = 1'b1;
    rst = 1'b0;
    tick();
    check("reboot_rd", bus.imem_rd, 1'b1);
    check("reboot_addr", bus.imem_addr, 8'h00);
    tick();
    check("reboot_instr", instr, 16'h8105);
    check("reboot_vld", instr_vld, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
